// File: rtl/sram_like_slave_mem_pkg.sv
// Shared encodings, response-entry layout and byte/LFSR helpers for the
// SRAM-like responder memory.
package sram_like_slave_mem_pkg;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2
   } size_e;

   localparam int DATA_W = 32;
   localparam int AGE_W  = 3;
   localparam int RESP_W = 1 + DATA_W + AGE_W;

   typedef struct packed {
      logic              is_wr;
      logic [DATA_W-1:0] rdata;
      logic [AGE_W-1:0]  age;
   } resp_entry_t;

   function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_word,
                                                     input logic [DATA_W-1:0] new_word,
                                                     input logic [3:0]        strb);
      logic [DATA_W-1:0] res;
      res = old_word;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
      end
      return res;
   endfunction

   // Fibonacci form of x^8+x^6+x^5+x^4+1 (taps on bits 7,5,4,3)
   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return {s[6:0], ^(s & 8'hB8)};
   endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// In-order response queue: each entry carries its read data and an age
// counter; the head is ready once its age reaches LAT-1.
module sram_resp_fifo
   import sram_like_slave_mem_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int LAT   = 2
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      push,
   input  logic                      push_is_wr,
   input  logic [DATA_W-1:0]         push_rdata,
   input  logic                      pop,
   output logic                      head_ready,
   output logic                      head_is_wr,
   output logic [DATA_W-1:0]         head_rdata,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(LAT);
   localparam logic [AGE_W-1:0] AGE_RDY = AGE_W'(LAT - 1);

   resp_entry_t   ent_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [PW:0]   count_r;

   assign head_ready = (count_r != (PW+1)'(0)) && (ent_r[rd_ptr_r].age >= AGE_RDY);
   assign head_is_wr = ent_r[rd_ptr_r].is_wr;
   assign head_rdata = ent_r[rd_ptr_r].rdata;
   assign count      = count_r;

   // Entry storage, saturating ages, pointers and occupancy
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) ent_r[i] <= '0;
         wr_ptr_r <= PW'(0);
         rd_ptr_r <= PW'(0);
         count_r  <= (PW+1)'(0);
      end else begin
         // idle slots age too; harmless since only the valid head is ever inspected
         for (int i = 0; i < DEPTH; i++) begin
            if (ent_r[i].age != AGE_MAX) ent_r[i].age <= ent_r[i].age + AGE_W'(1);
         end
         if (push) begin
            ent_r[wr_ptr_r].is_wr <= push_is_wr;
            ent_r[wr_ptr_r].rdata <= push_rdata;
            ent_r[wr_ptr_r].age   <= AGE_W'(0);
            wr_ptr_r              <= wr_ptr_r + PW'(1);
         end
         if (pop) rd_ptr_r <= rd_ptr_r + PW'(1);
         case ({push, pop})
            2'b10:   count_r <= count_r + (PW+1)'(1);
            2'b01:   count_r <= count_r - (PW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/sram_like_slave_mem.sv
// SRAM-like bus responder: word array with byte-strobed writes, fixed-latency
// in-order responses and optional LFSR back-pressure on addr_ok.
module sram_like_slave_mem
   import sram_like_slave_mem_pkg::*;
#(
   parameter int       AW        = 10,
   parameter int       LAT       = 2,
   parameter int       OUTSTAND  = 4,
   parameter int       STALL_EN  = 0,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   localparam int CW = $clog2(OUTSTAND) + 1;

   logic [31:0]   mem_r [0:(1<<AW)-1];
   logic          addr_ok_r;
   logic          data_ok_r;
   logic [31:0]   rdata_r;
   logic [7:0]    lfsr_r;
   logic [7:0]    lfsr_nxt_s;
   logic          accept_s;
   logic          pop_s;
   logic          head_is_wr_s;
   logic [31:0]   head_rdata_s;
   logic [CW-1:0] count_s;
   logic [CW-1:0] count_nxt_s;
   logic [AW-1:0] idx_s;
   logic          unused_s;

   assign idx_s    = addr[AW+1:2];
   assign accept_s = req & addr_ok_r;
   assign unused_s = ^{size, addr[31:AW+2], addr[1:0]};

   assign addr_ok = addr_ok_r;
   assign data_ok = data_ok_r;
   assign rdata   = rdata_r;

   sram_resp_fifo #(
      .DEPTH (OUTSTAND),
      .LAT   (LAT)
   ) u_fifo (
      .clk        (clk),
      .resetn     (resetn),
      .push       (accept_s),
      .push_is_wr (wr),
      .push_rdata (wr ? 32'h0000_0000 : mem_r[idx_s]),
      .pop        (pop_s),
      .head_ready (pop_s),
      .head_is_wr (head_is_wr_s),
      .head_rdata (head_rdata_s),
      .count      (count_s)
   );

   // LFSR only moves when back-pressure is enabled
   always_comb begin
      if (STALL_EN != 0) lfsr_nxt_s = lfsr_step(lfsr_r);
      else               lfsr_nxt_s = lfsr_r;
   end

   // Occupancy after this edge, used to precompute next cycle's addr_ok
   always_comb begin
      count_nxt_s = count_s;
      case ({accept_s, pop_s})
         2'b10:   count_nxt_s = count_s + CW'(1);
         2'b01:   count_nxt_s = count_s - CW'(1);
         default: count_nxt_s = count_s;
      endcase
   end

   // Word array: writes land at the accept edge so later reads see them
   always_ff @(posedge clk) begin
      if (accept_s && wr) mem_r[idx_s] <= merge_bytes(mem_r[idx_s], wdata, wstrb);
   end

   // Output registers; addr_ok_r doubles as the post-reset ready flop
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         addr_ok_r <= 1'b0;
         data_ok_r <= 1'b0;
         rdata_r   <= 32'h0000_0000;
         lfsr_r    <= LFSR_SEED;
      end else begin
         lfsr_r    <= lfsr_nxt_s;
         addr_ok_r <= (count_nxt_s < CW'(OUTSTAND)) && ((STALL_EN == 0) || lfsr_nxt_s[0]);
         if (pop_s) begin
            data_ok_r <= 1'b1;
            rdata_r   <= head_is_wr_s ? 32'h0000_0000 : head_rdata_s;
         end else begin
            data_ok_r <= 1'b0;
         end
      end
   end

endmodule
